// File: rtl/tile_cfg_pkg.sv
// Shared types and sizing helpers for the tile bank configuration loader.
package tile_cfg_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StFill,
        StSetup,
        StPulse,
        StHold,
        StFinish,
        StErr
    } state_e;

    // Header word layout: start row sits at bit 0, n_rows_m1 directly above it.
    localparam int unsigned HdrRowLsb = 0;

    function automatic int unsigned hdr_nrows_lsb(input int unsigned row_w);
        return HdrRowLsb + row_w;
    endfunction

    // Row index width; never zero so a single-row bank still gets a 1-bit counter.
    function automatic int unsigned calc_row_w(input int unsigned num_wl);
        return (num_wl > 1) ? $clog2(num_wl) : 1;
    endfunction

    // Number of stream words needed to fill one bitline row.
    function automatic int unsigned calc_chunks(input int unsigned num_bl,
                                                input int unsigned data_w);
        return (num_bl + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/cfg_row_assembler.sv
// Assembles one bitline row from DATA_W-wide chunks; bits past NUM_BL are dropped.
module cfg_row_assembler
    import tile_cfg_pkg::*;
#(
    parameter int unsigned NUM_BL = 1260,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              chunk_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [NUM_BL-1:0] bl,
    output logic              last_chunk
);

    localparam int unsigned CHUNKS  = calc_chunks(NUM_BL, DATA_W);
    localparam int unsigned CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic [NUM_BL-1:0]  bl_q, bl_d;

    assign last_chunk = (chunk_q == CHUNK_W'(CHUNKS - 1));
    assign bl         = bl_q;

    // Next chunk index: wraps after the final chunk so the next row starts at 0.
    always_comb begin
        chunk_d = chunk_q;
        if (clear || chunk_rst) begin
            chunk_d = '0;
        end else if (wr_en) begin
            chunk_d = last_chunk ? '0 : chunk_q + CHUNK_W'(1);
        end
    end

    // Next row contents: each bit takes its slot of the current chunk.
    always_comb begin
        bl_d = bl_q;
        if (clear) begin
            bl_d = '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_BL; i++) begin
                if (CHUNK_W'(i / DATA_W) == chunk_q) begin
                    bl_d[i] = wr_data[i % DATA_W];
                end
            end
        end
    end

    // Chunk counter and row register.
    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_q <= '0;
            bl_q    <= '0;
        end else begin
            chunk_q <= chunk_d;
            bl_q    <= bl_d;
        end
    end

endmodule

// File: rtl/tile_bank_cfg_loader.sv
// Streams configuration rows into a tile bank: header, row chunks, one wordline pulse per row.
module tile_bank_cfg_loader
    import tile_cfg_pkg::*;
#(
    parameter int unsigned NUM_BL   = 1260,
    parameter int unsigned NUM_WL   = 64,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WL_PULSE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_all,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned ROW_W     = calc_row_w(NUM_WL);
    localparam int unsigned NROWS_LSB = hdr_nrows_lsb(ROW_W);
    localparam int unsigned PCNT_W    = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  last_q, last_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              clear_q, clear_d;
    logic              err_q, err_d;

    logic              asm_clear;
    logic              asm_chunk_rst;
    logic              asm_wr;
    logic              asm_last_chunk;

    logic [ROW_W-1:0]  hdr_row;
    logic [ROW_W-1:0]  hdr_nrows;
    logic [ROW_W:0]    hdr_last;

    assign hdr_row   = in_data[HdrRowLsb +: ROW_W];
    assign hdr_nrows = in_data[NROWS_LSB +: ROW_W];
    // One extra bit so an overflowing range is caught instead of wrapping.
    assign hdr_last  = {1'b0, hdr_row} + {1'b0, hdr_nrows};

    cfg_row_assembler #(
        .NUM_BL (NUM_BL),
        .DATA_W (DATA_W)
    ) u_row_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .chunk_rst  (asm_chunk_rst),
        .wr_en      (asm_wr),
        .wr_data    (in_data),
        .bl         (bl),
        .last_chunk (asm_last_chunk)
    );

    // Next-state logic and assembler control.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        last_d        = last_q;
        pcnt_d        = pcnt_q;
        clear_d       = clear_q;
        err_d         = err_q;
        asm_clear     = 1'b0;
        asm_chunk_rst = 1'b0;
        asm_wr        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d         = 1'b0;
                    clear_d       = clear_all;
                    asm_chunk_rst = 1'b1;
                    if (clear_all) begin
                        row_d     = '0;
                        last_d    = ROW_W'(NUM_WL - 1);
                        asm_clear = 1'b1;
                        state_d   = StSetup;
                    end else begin
                        state_d   = StHdr;
                    end
                end
            end
            StHdr: begin
                if (in_valid) begin
                    row_d = hdr_row;
                    if (hdr_last >= (ROW_W + 1)'(NUM_WL)) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        last_d  = hdr_last[ROW_W-1:0];
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (in_valid) begin
                    asm_wr = 1'b1;
                    if (asm_last_chunk) begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                pcnt_d  = '0;
                state_d = StPulse;
            end
            StPulse: begin
                if (pcnt_q == PCNT_W'(WL_PULSE - 1)) begin
                    state_d = StHold;
                end else begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                end
            end
            StHold: begin
                if (row_q == last_q) begin
                    state_d = StFinish;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = clear_q ? StSetup : StFill;
                end
            end
            StFinish: state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore outputs; wordline is only ever driven for the current row during PULSE.
    always_comb begin
        wl       = '0;
        in_ready = (state_q == StHdr) || (state_q == StFill);
        busy     = (state_q != StIdle) && (state_q != StErr);
        done     = (state_q == StFinish);
        err      = err_q;
        if (state_q == StPulse) begin
            wl[row_q] = 1'b1;
        end
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            last_q  <= '0;
            pcnt_q  <= '0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            last_q  <= last_d;
            pcnt_q  <= pcnt_d;
            clear_q <= clear_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tile_bank_cfg_loader.sv
// Directed bench for tile_bank_cfg_loader (NUM_BL=20, NUM_WL=16, DATA_W=8, WL_PULSE=2).
module tb_tile_bank_cfg_loader;

    localparam int unsigned NUM_BL   = 20;
    localparam int unsigned NUM_WL   = 16;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned WL_PULSE = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              clear_all = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [NUM_BL-1:0] bl;
    logic [NUM_WL-1:0] wl;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad   = 0;

    tile_bank_cfg_loader #(
        .NUM_BL   (NUM_BL),
        .NUM_WL   (NUM_WL),
        .DATA_W   (DATA_W),
        .WL_PULSE (WL_PULSE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clear_all (clear_all),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bl        (bl),
        .wl        (wl),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one word and hold it until the handshake edge has passed.
    task automatic send(input logic [DATA_W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("send_timeout", n, 0);
        tick();
        in_valid = 1'b0;
    endtask

    // Idle gaps with in_valid low before sending a chunk; nothing may be pulsed meanwhile.
    task automatic send_gap(input logic [DATA_W-1:0] d, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
            tick();
            chk("t5_gap_wl", wl, 0);
            chk("t5_gap_ready", in_ready, 1);
        end
        send(d);
    endtask

    // Entered in SETUP; walks SETUP, PULSE x2, HOLD and leaves the bench in HOLD.
    task automatic do_row(input string tag, input int r);
        logic [NUM_WL-1:0] exp_wl;
        exp_wl = NUM_WL'(1) << r;
        chk({tag, "_setup_wl"}, wl, 0);
        tick();
        chk({tag, "_pulse0_wl"}, wl, exp_wl);
        tick();
        chk({tag, "_pulse1_wl"}, wl, exp_wl);
        tick();
        chk({tag, "_hold_wl"}, wl, 0);
        chk({tag, "_hold_ready"}, in_ready, 0);
        chk({tag, "_hold_done"}, done, 0);
    endtask

    task automatic start_txn(input logic clr);
        start     = 1'b1;
        clear_all = clr;
        tick();
        start     = 1'b0;
        clear_all = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        chk("rst_wl", wl, 0);
        chk("rst_bl", bl, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        tick();

        // 1: single row 3, three chunks.
        start_txn(1'b0);
        chk("t1_busy", busy, 1);
        chk("t1_hdr_ready", in_ready, 1);
        send(8'h03);
        send(8'hA5);
        send(8'h3C);
        send(8'hFF);
        chk("t1_bl", bl, 20'hF3CA5);
        chk("t1_setup_ready", in_ready, 0);
        do_row("t1", 3);
        tick();
        chk("t1_done", done, 1);
        chk("t1_finish_busy", busy, 1);
        tick();
        chk("t1_done_end", done, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_bl", bl, 20'hF3CA5);

        // 2: rows 14 and 15.
        start_txn(1'b0);
        send(8'h1E);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        chk("t2_bl14", bl, 20'h32211);
        do_row("t2_r14", 14);
        tick();
        chk("t2_fill_ready", in_ready, 1);
        chk("t2_fill_wl", wl, 0);
        send(8'h44);
        send(8'h55);
        send(8'h66);
        chk("t2_bl15", bl, 20'h65544);
        do_row("t2_r15", 15);
        tick();
        chk("t2_done", done, 1);
        tick();
        chk("t2_idle_busy", busy, 0);

        // 3: range error (10 + 6 = 16).
        start_txn(1'b0);
        send(8'h6A);
        chk("t3_err", err, 1);
        chk("t3_err_busy", busy, 0);
        chk("t3_err_ready", in_ready, 0);
        chk("t3_err_wl", wl, 0);
        chk("t3_err_done", done, 0);
        tick();
        chk("t3_idle_err", err, 1);
        chk("t3_idle_ready", in_ready, 0);
        chk("t3_idle_wl", wl, 0);

        // 4: clear all rows; start also clears the sticky error.
        start_txn(1'b1);
        chk("t4_err_cleared", err, 0);
        chk("t4_busy", busy, 1);
        chk("t4_bl", bl, 0);
        for (int r = 0; r < 16; r++) begin
            chk("t4_ready", in_ready, 0);
            do_row("t4", r);
            tick();
        end
        chk("t4_done", done, 1);
        chk("t4_bl_end", bl, 0);
        tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_done", done, 0);

        // 5: stalled stream, same result as test 1.
        start_txn(1'b0);
        send(8'h03);
        send_gap(8'hA5, int'($urandom_range(1, 3)));
        send_gap(8'h3C, int'($urandom_range(1, 3)));
        send_gap(8'hFF, int'($urandom_range(1, 3)));
        chk("t5_bl", bl, 20'hF3CA5);
        do_row("t5", 3);
        tick();
        chk("t5_done", done, 1);
        tick();

        // 6: reset in the middle of a pulse, then a normal transaction.
        start_txn(1'b0);
        send(8'h03);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("t6_bl", bl, 20'h30201);
        tick();
        chk("t6_pulse_wl", wl, 16'h0008);
        reset = 1'b1;
        tick();
        chk("t6_rst_wl", wl, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_bl", bl, 0);
        reset = 1'b0;
        tick();
        start_txn(1'b0);
        send(8'h00);
        send(8'h5A);
        send(8'hC3);
        send(8'h07);
        chk("t6_after_bl", bl, 20'h7C35A);
        do_row("t6_after", 0);
        tick();
        chk("t6_after_done", done, 1);
        tick();
        chk("t6_after_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
